// File: rtl/demux4_router.sv
// 1:4 data router with latched lane select and a sequenced lane flush.
// Optional per-lane saturating hit counters are enabled with DEMUX4_HIT_COUNT_EN.
module demux4_router #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         sel_in,
  input  logic               sel_load,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  input  logic               clr,
  output logic [4*WIDTH-1:0] lane_data,
  output logic [3:0]         lane_strobe,
  output logic [1:0]         sel_q,
  output logic [3:0]         disp,
  output logic               busy
`ifdef DEMUX4_HIT_COUNT_EN
  ,
  output logic [4*CNT_W-1:0] hit_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] flush_cnt;
  logic       flush_ret;
  logic       wr_en;

  assign in_ready = (state == ACTIVE) && !clr;
  assign wr_en    = in_valid && in_ready;
  assign busy     = (state == FLUSH);
  assign disp     = (state == ACTIVE) ? {2'b00, sel_q} : 4'b1111;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (clr)           state_nxt = FLUSH;
        else if (sel_load) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (clr) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == 2'd3) state_nxt = flush_ret ? ACTIVE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the lane registers are reset explicitly because their contents are
  // visible on lane_data straight after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= 2'd0;
      lane_data   <= '0;
      lane_strobe <= 4'b0000;
      flush_cnt   <= 2'd0;
      flush_ret   <= 1'b0;
    end else begin
      lane_strobe <= 4'b0000;
      unique case (state)
        IDLE: begin
          if (clr)           flush_ret <= 1'b0;
          else if (sel_load) sel_q     <= sel_in;
        end
        ACTIVE: begin
          if (clr) begin
            flush_ret <= 1'b1;
          end else begin
            // A write in the same cycle as sel_load still targets the old lane.
            if (wr_en) begin
              lane_data[sel_q*WIDTH +: WIDTH] <= in_data;
              lane_strobe                     <= 4'b0001 << sel_q;
            end
            if (sel_load) sel_q <= sel_in;
          end
        end
        FLUSH: begin
          lane_data[flush_cnt*WIDTH +: WIDTH] <= '0;
          flush_cnt                           <= flush_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef DEMUX4_HIT_COUNT_EN
  logic [CNT_W-1:0] hits [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) hits[i] <= '0;
    end else if (state == FLUSH) begin
      hits[flush_cnt] <= '0;
    end else if (wr_en && (hits[sel_q] != {CNT_W{1'b1}})) begin
      hits[sel_q] <= hits[sel_q] + CNT_W'(1);
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_hit
    assign hit_cnt[n*CNT_W +: CNT_W] = hits[n];
  end
`endif

endmodule

// File: tb/tb_demux4_router.sv
// Self-checking bench for demux4_router: directed scenarios plus a randomized
// run compared against a lane-array reference model.
module tb_demux4_router;
  localparam int W  = 1;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   sel_in;
  logic         sel_load;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         clr;
  logic [4*W-1:0] lane_data;
  logic [3:0]   lane_strobe;
  logic [1:0]   sel_q;
  logic [3:0]   disp;
  logic         busy;
`ifdef DEMUX4_HIT_COUNT_EN
  logic [4*CW-1:0] hit_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  demux4_router #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .sel_in(sel_in), .sel_load(sel_load),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .clr(clr),
    .lane_data(lane_data), .lane_strobe(lane_strobe), .sel_q(sel_q),
    .disp(disp), .busy(busy)
`ifdef DEMUX4_HIT_COUNT_EN
    , .hit_cnt(hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 routing, 2 flushing.
  int m_mode;
  int m_sel;
  int m_lane [4];
  int m_hits [4];
  int m_strobe;
  int m_left;
  int m_ret;

  task automatic set_in(input logic r, input logic sl, input logic [1:0] si,
                        input logic v, input logic d, input logic c);
    reset = r; sel_load = sl; sel_in = si; in_valid = v; in_data = d; clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic sl, input logic [1:0] si,
                            input logic v, input logic d, input logic c);
    m_strobe = -1;
    if (r) begin
      m_mode = 0; m_sel = 0; m_left = 0; m_ret = 0;
      for (int i = 0; i < 4; i++) begin m_lane[i] = 0; m_hits[i] = 0; end
    end else if (m_mode == 0) begin
      if (c) begin m_mode = 2; m_left = 4; m_ret = 0; end
      else if (sl) begin m_mode = 1; m_sel = si; end
    end else if (m_mode == 1) begin
      if (c) begin
        m_mode = 2; m_left = 4; m_ret = 1;
      end else begin
        if (v) begin
          m_lane[m_sel] = d;
          m_strobe = m_sel;
          if (m_hits[m_sel] < (1 << CW) - 1) m_hits[m_sel]++;
        end
        if (sl) m_sel = si;
      end
    end else begin
      m_lane[4 - m_left] = 0;
      m_hits[4 - m_left] = 0;
      m_left--;
      if (m_left == 0) m_mode = m_ret ? 1 : 0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    set_in(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    tick();
    n_checks++;
    if (lane_data !== 4'b0000) begin n_fail++; $display("FAIL reset_lanes: got %b want 0000", lane_data); end
    n_checks++;
    if (lane_strobe !== 4'b0000) begin n_fail++; $display("FAIL reset_strobe: got %b want 0000", lane_strobe); end
    n_checks++;
    if (disp !== 4'b1111) begin n_fail++; $display("FAIL reset_disp: got %b want 1111", disp); end
    n_checks++;
    if (busy !== 1'b0 || sel_q !== 2'd0) begin
      n_fail++; $display("FAIL reset_busy_sel: got busy=%b sel_q=%0d want 0 0", busy, sel_q);
    end
  endtask

  task automatic test_write();
    do_reset();
    set_in(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (disp !== 4'b0010) begin n_fail++; $display("FAIL write_disp: got %b want 0010", disp); end
    set_in(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL write_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (lane_data !== 4'b0100) begin n_fail++; $display("FAIL write_lanes: got %b want 0100", lane_data); end
    n_checks++;
    if (lane_strobe !== 4'b0100) begin n_fail++; $display("FAIL write_strobe: got %b want 0100", lane_strobe); end
    tick();
    n_checks++;
    if (lane_strobe !== 4'b0000 || lane_data !== 4'b0100) begin
      n_fail++; $display("FAIL write_hold: got strobe=%b lanes=%b want 0000 0100", lane_strobe, lane_data);
    end
  endtask

  task automatic test_sel_change();
    do_reset();
    set_in(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (lane_data !== 4'b0010) begin n_fail++; $display("FAIL selchg_lanes: got %b want 0010", lane_data); end
    n_checks++;
    if (sel_q !== 2'd3 || disp !== 4'b0011) begin
      n_fail++; $display("FAIL selchg_sel: got sel_q=%0d disp=%b want 3 0011", sel_q, disp);
    end
  endtask

  task automatic test_flush();
    logic [3:0] steps [4];
    steps[0] = 4'b1110; steps[1] = 4'b1100; steps[2] = 4'b1000; steps[3] = 4'b0000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, 2'(i), 1'b0, 1'b0, 1'b0);
      tick();
      set_in(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    n_checks++;
    if (lane_data !== 4'b1111) begin n_fail++; $display("FAIL flush_fill: got %b want 1111", lane_data); end
    // clr wins over a write of 0 to lane 3 and over a select change.
    set_in(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_clr_ready: got %b want 0", in_ready); end
    tick();
    n_checks++;
    if (busy !== 1'b1 || sel_q !== 2'd3 || lane_strobe !== 4'b0000 || disp !== 4'b1111) begin
      n_fail++;
      $display("FAIL flush_enter: got busy=%b sel_q=%0d strobe=%b disp=%b want 1 3 0000 1111",
               busy, sel_q, lane_strobe, disp);
    end
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, k == 1);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready_%0d: got %b want 0", k, in_ready); end
      tick();
      n_checks++;
      if (lane_data !== steps[k] || busy !== (k < 3) || lane_strobe !== 4'b0000) begin
        n_fail++;
        $display("FAIL flush_step_%0d: got lanes=%b busy=%b strobe=%b want %b %b 0000",
                 k, lane_data, busy, lane_strobe, steps[k], k < 3);
      end
    end
    set_in(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (sel_q !== 2'd3 || disp !== 4'b0011) begin
      n_fail++; $display("FAIL flush_return: got sel_q=%0d disp=%b want 3 0011", sel_q, disp);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (lane_data !== 4'b1000 || lane_strobe !== 4'b1000) begin
      n_fail++; $display("FAIL flush_resume: got lanes=%b strobe=%b want 1000 1000", lane_data, lane_strobe);
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    set_in(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || lane_data !== 4'b0000 || sel_q !== 2'd0 || disp !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_mid_flush: got busy=%b lanes=%b sel_q=%0d disp=%b want 0 0000 0 1111",
               busy, lane_data, sel_q, disp);
    end
  endtask

  task automatic test_flush_from_idle();
    do_reset();
    set_in(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    clr = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if (busy !== 1'b0 || disp !== 4'b1111) begin
      n_fail++; $display("FAIL idle_flush_return: got busy=%b disp=%b want 0 1111", busy, disp);
    end
  endtask

`ifdef DEMUX4_HIT_COUNT_EN
  task automatic test_hit_count();
    do_reset();
    set_in(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    in_valid = 1'b0;
    n_checks++;
    if (hit_cnt !== 8'b0000_0011) begin n_fail++; $display("FAIL hit_saturate: got %b want 00000011", hit_cnt); end
    set_in(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    clr = 1'b0;
    n_checks++;
    if (hit_cnt !== 8'b0000_0111) begin n_fail++; $display("FAIL hit_lane1: got %b want 00000111", hit_cnt); end
    tick();
    n_checks++;
    if (hit_cnt !== 8'b0000_0100) begin n_fail++; $display("FAIL hit_flush: got %b want 00000100", hit_cnt); end
    for (int k = 0; k < 3; k++) tick();
  endtask
`endif

  task automatic test_random();
    logic r, sl, v, d, c;
    logic [1:0] si;
    logic [3:0] e_lanes, e_strobe, e_disp;
`ifdef DEMUX4_HIT_COUNT_EN
    logic [4*CW-1:0] e_hits;
`endif
    do_reset();
    model_step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 79) == 0);
      sl = ($urandom_range(0, 4) == 0);
      si = 2'($urandom);
      v  = 1'($urandom);
      d  = 1'($urandom);
      c  = ($urandom_range(0, 14) == 0);
      if (m_mode == 0 && c) sl = 1'b0;
      set_in(r, sl, si, v, d, c);
      #1;
      n_checks++;
      if (in_ready !== (m_mode == 1 && !c)) begin
        n_fail++; $display("FAIL rnd_ready @%0d: got %b want %b", n, in_ready, m_mode == 1 && !c);
      end
      @(posedge clk);
      model_step(r, sl, si, v, d, c);
      #1;
      for (int i = 0; i < 4; i++) e_lanes[i] = 1'(m_lane[i]);
      e_strobe = (m_strobe < 0) ? 4'b0000 : 4'(1 << m_strobe);
      e_disp   = (m_mode == 1) ? 4'(m_sel) : 4'b1111;
      n_checks++;
      if (lane_data !== e_lanes || lane_strobe !== e_strobe) begin
        n_fail++;
        $display("FAIL rnd_lanes @%0d: got lanes=%b strobe=%b want %b %b", n, lane_data, lane_strobe, e_lanes, e_strobe);
      end
      n_checks++;
      if (sel_q !== 2'(m_sel) || disp !== e_disp || busy !== (m_mode == 2)) begin
        n_fail++;
        $display("FAIL rnd_ctrl @%0d: got sel_q=%0d disp=%b busy=%b want %0d %b %b",
                 n, sel_q, disp, busy, m_sel, e_disp, m_mode == 2);
      end
`ifdef DEMUX4_HIT_COUNT_EN
      for (int i = 0; i < 4; i++) e_hits[i*CW +: CW] = CW'(m_hits[i]);
      n_checks++;
      if (hit_cnt !== e_hits) begin n_fail++; $display("FAIL rnd_hits @%0d: got %b want %b", n, hit_cnt, e_hits); end
`endif
    end
  endtask

  initial begin
    set_in(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_write();
    test_sel_change();
    test_flush();
    test_reset_mid_flush();
    test_flush_from_idle();
`ifdef DEMUX4_HIT_COUNT_EN
    test_hit_count();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux4_router.md
Name: demux4_router

Overview:
- Inverse of the 4:1 key-select path: one data input is routed to one of four output lanes.
- Select is a 2-bit code latched from the keys; disp shows the active lane code on the board display.
- Each lane register holds its last routed value until it is overwritten or cleared by a sequenced flush.
- Sits between the key/switch inputs and the LED/display outputs in the board top level.

Parameters:
- WIDTH, 1, data width of the input and of each lane.
- CNT_W, 8, width of the per-lane hit counters (optional feature only).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-high.
- sel_in  input  2  lane select code (0..3).
- sel_load  input  1  one-cycle strobe; latch sel_in into sel_q.
- in_valid  input  1  data-valid strobe.
- in_data  input  WIDTH  data to route.
- in_ready  output  1  high when a write is accepted this cycle.
- clr  input  1  one-cycle strobe; start the lane flush.
- lane_data  output  4*WIDTH  lane n occupies bits [n*WIDTH +: WIDTH].
- lane_strobe  output  4  one-cycle pulse on the lane written in the previous cycle.
- sel_q  output  2  latched select.
- disp  output  4  {2'b00, sel_q} in ACTIVE; 4'b1111 in IDLE and FLUSH.
- busy  output  1  high during FLUSH.

Behaviour:
- States:
  - IDLE: no select latched.
  - ACTIVE: routing enabled.
  - FLUSH: clearing lanes.
- Reset values (reset sampled on the clk edge):
  - state=IDLE, sel_q=0, lane_data=0, lane_strobe=0, busy=0, disp=4'b1111.
  - Flush counter=0.
  - Hit counters=0 when the optional feature is compiled in.
- Reset mid-FLUSH aborts the flush and applies the full reset values.
- in_ready = (state==ACTIVE) && !clr. The signal is combinational.
- IDLE:
  - sel_load -> sel_q<=sel_in, go to ACTIVE.
  - in_valid is ignored; data is dropped and no strobe is issued.
  - clr -> FLUSH.
- ACTIVE write:
  - in_valid && in_ready -> lane[sel_q]<=in_data on that edge.
  - lane_strobe[sel_q]=1 for exactly the next cycle.
  - Other lanes are unchanged.
- ACTIVE select change:
  - sel_load -> sel_q<=sel_in; the new lane is used from the next cycle.
  - sel_load with in_valid in the same cycle: data goes to the OLD sel_q.
- ACTIVE flush:
  - clr -> FLUSH.
  - clr has priority over a simultaneous in_valid (write dropped) and over sel_load (ignored).
- FLUSH:
  - Clears one lane per cycle, lane 0..3 in order, over 4 cycles.
  - busy=1 throughout; in_ready=0; sel_load and clr are ignored.
  - After lane 3 clears: return to ACTIVE if a select had been latched before the flush, else IDLE.
  - sel_q is preserved across FLUSH.
  - lane_strobe is not asserted for flush clears.
- Latency:
  - Write to lane_data: 1 clk.
  - sel_load to disp: 1 clk.
  - clr to all lanes zero: 4 clks after the clr edge.
- lane_strobe is at most one-hot at any time.

Optional Feature:
- Macro: DEMUX4_HIT_COUNT_EN.
- Enabled:
  - Adds output hit_cnt, 4*CNT_W wide; lane n occupies bits [n*CNT_W +: CNT_W].
  - Each accepted write to lane n increments count n.
  - Counts saturate at all-ones (no wrap-around).
  - FLUSH zeroes each count in the same cycle its lane is cleared.
- Disabled: hit_cnt does not exist; no counter logic.

Test Plan:
- Reset, then in_valid=1 with in_data=1, no sel_load -> in_ready=0; lane_data=4'b0000; lane_strobe=0; disp=4'b1111.
- sel_in=2 with sel_load, then in_data=1 with in_valid -> next cycle lane_data=4'b0100, lane_strobe=4'b0100, disp=4'b0010.
- In ACTIVE with sel_q=1: sel_in=3, sel_load and in_valid (in_data=1) in the same cycle -> lane 1 written (lane_data=4'b0010), sel_q=3 next cycle.
- Lanes=4'b1111, assert clr -> busy=1 for 4 cycles; lane_data steps 4'b1110, 4'b1100, 4'b1000, 4'b0000; state returns to ACTIVE with sel_q unchanged.
- Reset asserted on the 2nd FLUSH cycle -> next cycle busy=0, lane_data=0, sel_q=0, disp=4'b1111.
- With DEMUX4_HIT_COUNT_EN and CNT_W=2: five writes to lane 0 -> hit_cnt[1:0]=2'b11 (saturated); other lane counts = 0.
